sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO with integrated controller and storage, replacing the fixed 4x8 FIFO controller/datapath pair.
- Buffers data between producer and consumer in the same clock domain (e.g. the RFID baseband TX/RX byte paths).
- Adds the following, which the fixed design lacks:
  - configurable width and depth
  - occupancy count
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow error flags
  - synchronous clear
  - single-cycle accept (no two-cycle write handshake)

---
 rtl/fifo_pkg.sv | 13 +
 rtl/sync_fifo_param_if.sv | 35 +++
 rtl/fifo_ram_2p.sv | 23 ++
 rtl/sync_fifo_param.sv | 110 +++++++++++
 tb/tb_sync_fifo_param.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFOs.
package fifo_pkg;

  // Defaults sized for the RFID baseband TX/RX byte paths.
  localparam int RFID_DATA_WIDTH = 8;
  localparam int RFID_DEPTH      = 4;

  // Address width for a power-of-two depth.
  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer side of sync_fifo_param: requests in, data and status out.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = RFID_DATA_WIDTH,
  parameter int DEPTH      = RFID_DEPTH
);
  localparam int ADDR_W = fifo_addr_w(DEPTH);

  logic                  clear;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_W:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, write_en, data_in, read_en,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, write_en, data_in, read_en,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram_2p.sv
// Simple dual-port storage: synchronous write, combinational read address.
module fifo_ram_2p #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: wrap-bit pointers, occupancy flags,
// sticky overflow/underflow and a registered read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = RFID_DATA_WIDTH,
  parameter int DEPTH      = RFID_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  sync_fifo_param_if.slave bus
);

  localparam int              ADDR_W  = fifo_addr_w(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF_CMP  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CMP  = (ADDR_W+1)'(AE_LEVEL);

  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full, empty;
  logic [ADDR_W:0]       count;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
            (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    count = wr_ptr_q - rd_ptr_q;
  end

  // Both requests are qualified against pre-edge flags; clear overrides both.
  assign wr_accept = bus.write_en && !full  && !bus.clear;
  assign rd_accept = bus.read_en  && !empty && !bus.clear;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (bus.clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_accept) begin
        rd_ptr_d     = rd_ptr_q + PTR_ONE;
        data_out_d   = ram_rdata;
        data_valid_d = 1'b1;
      end
      if (bus.write_en && full)  overflow_d  = 1'b1;
      if (bus.read_en  && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  fifo_ram_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk   (clock),
    .we    (wr_accept),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_CMP);
  assign bus.almost_empty = (count <= AE_CMP);
  assign bus.count        = count;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed scenarios plus random traffic, all
// checked against a queue-based model of the FIFO.
module tb_sync_fifo_param;

  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int AF     = 3;
  localparam int AE     = 1;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = ADDR_W + 1;
  localparam int SW     = DW + 7 + CW;

  logic clock;
  logic reset_n;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout;
  logic          m_dv, m_ovf, m_udf;

  function automatic void model_reset();
    q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endfunction

  function automatic logic [SW-1:0] exp_status();
    int sz = q.size();
    logic [CW-1:0] c = CW'(sz);
    return {m_dout, m_dv, m_ovf, m_udf, sz == DEPTH, sz == 0, sz >= AF, sz <= AE, c};
  endfunction

  function automatic logic [SW-1:0] act_status();
    return {bus.data_out, bus.data_valid, bus.overflow, bus.underflow, bus.full,
            bus.empty, bus.almost_full, bus.almost_empty, bus.count};
  endfunction

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic tick();
    int  sz;
    bit  wr_ok, rd_ok;
    sz = q.size();
    @(posedge clock);
    if (bus.clear) begin
      q.delete();
      m_dv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      wr_ok = bus.write_en && (sz < DEPTH);
      rd_ok = bus.read_en  && (sz > 0);
      m_dv  = 1'b0;
      if (bus.write_en && !wr_ok) m_ovf = 1'b1;
      if (bus.read_en  && !rd_ok) m_udf = 1'b1;
      if (rd_ok) begin
        m_dout = q.pop_front();
        m_dv   = 1'b1;
      end
      if (wr_ok) q.push_back(bus.data_in);
    end
    #1;
  endtask

  task automatic drive(input logic clr, input logic we, input logic [DW-1:0] d, input logic re);
    bus.clear    = clr;
    bus.write_en = we;
    bus.data_in  = d;
    bus.read_en  = re;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (act_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL reset_status: got %h want %h", act_status(), exp_status());
    end
    #10 reset_n = 1'b1;
    @(negedge clock);
    tick();
    n_checks++;
    if (!(bus.empty === 1'b1 && bus.full === 1'b0 && bus.count === '0 &&
          bus.almost_empty === 1'b1 && bus.data_valid === 1'b0 &&
          bus.overflow === 1'b0 && bus.underflow === 1'b0)) begin
      n_errors++;
      $display("FAIL reset_idle: got %h want empty idle status", act_status());
    end
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, vals[i], 1'b0);
      tick();
      n_checks++;
      if (bus.count !== CW'(i + 1) || bus.almost_full !== (i >= 2) || bus.full !== (i == 3)) begin
        n_errors++;
        $display("FAIL fill_%0d: got count=%0d af=%b full=%b want count=%0d",
                 i, bus.count, bus.almost_full, bus.full, i + 1);
      end
    end
    drive(1'b0, 1'b1, 8'h55, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.count !== CW'(4) || act_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL overflow: got ovf=%b count=%0d want ovf=1 count=4", bus.overflow, bus.count);
    end
  endtask

  task automatic test_drain_underflow();
    logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0);
      n_checks++;
      if (bus.data_out !== vals[i] || bus.data_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL drain_%0d: got data=%h dv=%b want data=%h dv=1",
                 i, bus.data_out, bus.data_valid, vals[i]);
      end
      tick();
      n_checks++;
      if (bus.data_valid !== 1'b0 || act_status() !== exp_status()) begin
        n_errors++;
        $display("FAIL drain_pulse_%0d: got %h want %h", i, act_status(), exp_status());
      end
    end
    n_checks++;
    if (bus.empty !== 1'b1) begin
      n_errors++;
      $display("FAIL drained_empty: got %b want 1", bus.empty);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (bus.underflow !== 1'b1 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h44) begin
      n_errors++;
      $display("FAIL underflow: got udf=%b dv=%b data=%h want 1 0 44",
               bus.underflow, bus.data_valid, bus.data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] expect_q [$];
    expect_q = '{8'h01, 8'h02};
    drive(1'b0, 1'b1, 8'h01, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h02, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] want;
      drive(1'b0, 1'b1, DW'(8'hA0 + i), 1'b1);
      expect_q.push_back(DW'(8'hA0 + i));
      want = expect_q.pop_front();
      tick();
      n_checks++;
      if (bus.count !== CW'(2) || bus.data_out !== want || bus.data_valid !== 1'b1 ||
          act_status() !== exp_status()) begin
        n_errors++;
        $display("FAIL b2b_%0d: got count=%0d data=%h dv=%b want count=2 data=%h",
                 i, bus.count, bus.data_out, bus.data_valid, want);
      end
    end
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_clear();
    logic [DW-1:0] held;
    drive(1'b0, 1'b1, 8'hC3, 1'b0); tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (bus.count !== CW'(3) || bus.overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_setup: got count=%0d ovf=%b want 3 1", bus.count, bus.overflow);
    end
    held = bus.data_out;
    drive(1'b1, 1'b1, 8'hEE, 1'b0); tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (bus.count !== '0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 ||
        bus.underflow !== 1'b0 || bus.data_out !== held || act_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL clear: got %h want %h", act_status(), exp_status());
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 8'h71, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h72, 1'b1); tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (act_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL async_reset: got %h want %h", act_status(), exp_status());
    end
    #3 reset_n = 1'b1;
    @(negedge clock);
    drive(1'b0, 1'b1, 8'h5A, 1'b0); tick();
    drive(1'b0, 1'b0, '0, 1'b1); tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (bus.data_out !== 8'h5A || bus.data_valid !== 1'b1 || bus.empty !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_read: got data=%h dv=%b empty=%b want 5a 1 1",
               bus.data_out, bus.data_valid, bus.empty);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 55),
            DW'($urandom), ($urandom_range(0, 99) < 50));
      tick();
      n_checks++;
      if (act_status() !== exp_status()) begin
        n_errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: got %h want %h", i, act_status(), exp_status());
      end
    end
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
